// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes, index
// width helper and the write-port priority selector used by write and bypass paths.
package regfile_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_NUM_REGS = 32;
    localparam int ZERO_IDX     = 0;

    // Upper bound on write ports; the selector works on a fixed-width hit vector.
    localparam int MAX_WR = 16;
    localparam int WSEL_W = 4;

    function automatic int calc_addr_w(input int num_regs);
        return (num_regs > 2) ? $clog2(num_regs) : 1;
    endfunction

    // Highest-index set bit wins; callers qualify the result with |hits.
    function automatic logic [WSEL_W-1:0] win_port(input logic [MAX_WR-1:0] hits);
        logic [WSEL_W-1:0] sel;
        sel = '0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (hits[j]) sel = WSEL_W'(j);
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: writes clear, reservations set (set wins),
// register 0 optionally pinned to not-busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = calc_addr_w(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     resv_en,
    input  logic [ADDR_W-1:0]        resv_addr,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic                     resv_ok
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) busy_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
        end
        // Applied after the clears so a new producer stays outstanding.
        if (resv_en) busy_d[resv_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[ZERO_IDX] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;
    assign resv_ok  = !busy_q[resv_addr] ||
                      ((ZERO_REG != 0) && (resv_addr == ADDR_W'(ZERO_IDX)));

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass,
// hardwired-zero register, busy scoreboard and registered write-collision flag.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = calc_addr_w(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     resv_en,
    input  logic [ADDR_W-1:0]        resv_addr,
    output logic                     resv_ok,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic                     wr_collision
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd_pad [MAX_WR];
    logic              coll_q;
    logic              coll_d;

    // Write data padded to MAX_WR entries so win_port's index is always in range.
    always_comb begin
        for (int j = 0; j < MAX_WR; j++) wd_pad[j] = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wd_pad[j] = wr_data[j*DATA_W +: DATA_W];
            wa[j]     = wr_addr[j*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        logic [MAX_WR-1:0] hits;
        for (int r = 0; r < NUM_REGS; r++) begin
            mem_d[r] = mem_q[r];
            hits     = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                hits[j] = wr_en[j] && (wa[j] == ADDR_W'(r));
            end
            if ((|hits) && !((ZERO_REG != 0) && (r == ZERO_IDX))) begin
                mem_d[r] = wd_pad[win_port(hits)];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= mem_d[r];
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [MAX_WR-1:0] rhits;
        logic [DATA_W-1:0] val;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra    = rd_addr[k*ADDR_W +: ADDR_W];
            rhits = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                rhits[j] = wr_en[j] && (wa[j] == ra);
            end
            val = mem_q[ra];
            if ((BYPASS != 0) && (|rhits)) val = wd_pad[win_port(rhits)];
            if ((ZERO_REG != 0) && (ra == ADDR_W'(ZERO_IDX))) val = '0;
            rd_data[k*DATA_W +: DATA_W] = val;
            // Registered busy state only; same-cycle set/clear is not forwarded.
            rd_busy[k] = busy_vec[ra];
        end
    end

    always_comb begin
        coll_d = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_en[i] && wr_en[j] && (wa[i] == wa[j]) &&
                    !((ZERO_REG != 0) && (wa[i] == ADDR_W'(ZERO_IDX)))) begin
                    coll_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign wr_collision = coll_q;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .resv_en   (resv_en),
        .resv_addr (resv_addr),
        .busy_vec  (busy_vec),
        .resv_ok   (resv_ok)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomised checks of regfile_mp: a bypassing instance and a
// non-bypassing instance share all inputs.
module tb_regfile_mp;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data, nb_rd_data;
    logic [1:0]   rd_busy, nb_rd_busy;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [127:0] wr_data;
    logic         resv_en;
    logic [4:0]   resv_addr;
    logic         resv_ok, nb_resv_ok;
    logic [31:0]  busy_vec, nb_busy_vec;
    logic         wr_collision, nb_wr_collision;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] m_reg [32];
    logic [31:0] m_busy;
    logic        m_coll;

    always #5 clock = ~clock;

    regfile_mp u_dut (
        .clock (clock), .reset_n (reset_n),
        .rd_addr (rd_addr), .rd_data (rd_data), .rd_busy (rd_busy),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .resv_en (resv_en), .resv_addr (resv_addr), .resv_ok (resv_ok),
        .busy_vec (busy_vec), .wr_collision (wr_collision)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clock (clock), .reset_n (reset_n),
        .rd_addr (rd_addr), .rd_data (nb_rd_data), .rd_busy (nb_rd_busy),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .resv_en (resv_en), .resv_addr (resv_addr), .resv_ok (nb_resv_ok),
        .busy_vec (nb_busy_vec), .wr_collision (nb_wr_collision)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en   = '0;
        resv_en = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [63:0] d);
        wr_en[p]          = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*64 +: 64] = d;
    endtask

    task automatic rda(input int k, input logic [4:0] a);
        rd_addr[k*5 +: 5] = a;
    endtask

    function automatic logic [63:0] rd(input int k);
        return rd_data[k*64 +: 64];
    endfunction

    function automatic logic [63:0] nbrd(input int k);
        return nb_rd_data[k*64 +: 64];
    endfunction

    initial begin
        reset_n   = 1'b0;
        rd_addr   = '0;
        wr_addr   = '0;
        wr_data   = '0;
        resv_addr = '0;
        idle();
        #2;
        chk("reset_rd0", rd(0), 64'h0);
        chk("reset_busy", 64'(busy_vec), 64'h0);
        chk("reset_coll", 64'(wr_collision), 64'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Basic write/read, bypass versus stored value in the write cycle
        wr(0, 5'd5, 64'hDEADBEEF_00000005);
        rda(0, 5'd5);
        #1;
        chk("wr5_same_cycle_bypass", rd(0), 64'hDEADBEEF_00000005);
        chk("wr5_same_cycle_nobypass", nbrd(0), 64'h0);
        tick();
        idle();
        #1;
        chk("wr5_next_cycle", rd(0), 64'hDEADBEEF_00000005);
        chk("wr5_next_cycle_nb", nbrd(0), 64'hDEADBEEF_00000005);

        // Port 1 bypass
        wr(1, 5'd7, 64'h1234);
        rda(0, 5'd7);
        #1;
        chk("bypass_p1_r7", rd(0), 64'h1234);
        chk("nobypass_r7", nbrd(0), 64'h0);
        tick();
        idle();

        // Collision on r9, port 1 wins
        wr(0, 5'd9, 64'hAA);
        wr(1, 5'd9, 64'hBB);
        rda(0, 5'd9);
        #1;
        chk("coll_bypass_hi_wins", rd(0), 64'hBB);
        chk("coll_not_yet", 64'(wr_collision), 64'h0);
        tick();
        idle();
        #1;
        chk("coll_r9_stored", nbrd(0), 64'hBB);
        chk("coll_flag_set", 64'(wr_collision), 64'h1);
        tick();
        chk("coll_flag_one_cycle", 64'(wr_collision), 64'h0);

        // Both ports hit r0
        wr(0, 5'd0, 64'h11);
        wr(1, 5'd0, 64'h22);
        rda(1, 5'd0);
        #1;
        chk("r0_bypass_zero", rd(1), 64'h0);
        tick();
        idle();
        #1;
        chk("r0_stays_zero", nbrd(1), 64'h0);
        chk("r0_no_coll", 64'(wr_collision), 64'h0);

        // Scoreboard: reserve r3
        resv_addr = 5'd3;
        resv_en   = 1'b1;
        rda(0, 5'd3);
        #1;
        chk("resv3_ok_before", 64'(resv_ok), 64'h1);
        tick();
        idle();
        #1;
        chk("resv3_busy_vec", 64'(busy_vec), 64'h8);
        chk("resv3_ok_after", 64'(resv_ok), 64'h0);
        chk("resv3_rd_busy", 64'(rd_busy[0]), 64'h1);

        wr(0, 5'd3, 64'h33);
        #1;
        chk("wr3_rd_busy_no_fwd", 64'(rd_busy[0]), 64'h1);
        tick();
        idle();
        #1;
        chk("wr3_clears_busy", 64'(busy_vec), 64'h0);

        resv_en = 1'b1;
        tick();
        wr(0, 5'd3, 64'h34);
        #1;
        chk("resv3_again", 64'(busy_vec), 64'h8);
        tick();
        idle();
        #1;
        chk("set_wins_over_clear", 64'(busy_vec), 64'h8);
        wr(1, 5'd3, 64'h35);
        tick();
        idle();
        #1;
        chk("wr3_clear_again", 64'(busy_vec), 64'h0);

        resv_addr = 5'd0;
        resv_en   = 1'b1;
        #1;
        chk("resv0_ok", 64'(resv_ok), 64'h1);
        tick();
        idle();
        #1;
        chk("resv0_ignored", 64'(busy_vec), 64'h0);

        // Asynchronous reset mid-cycle
        wr(0, 5'd5, 64'h55);
        resv_addr = 5'd6;
        resv_en   = 1'b1;
        rda(0, 5'd5);
        rda(1, 5'd7);
        tick();
        idle();
        #1;
        chk("pre_reset_busy", 64'(busy_vec), 64'h40);
        chk("pre_reset_r5", rd(0), 64'h55);
        wr(1, 5'd5, 64'h77);
        resv_en = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_busy", 64'(busy_vec), 64'h0);
        chk("async_reset_r5_nb", nbrd(0), 64'h0);
        chk("async_reset_r7", rd(1), 64'h0);
        tick();
        idle();
        #2;
        reset_n = 1'b1;
        #1;
        chk("reset_aborts_write", nbrd(0), 64'h0);
        chk("reset_aborts_resv", 64'(busy_vec), 64'h0);
        tick();

        // Randomised phase against a reference model
        for (int r = 0; r < 32; r++) m_reg[r] = '0;
        m_busy = '0;
        m_coll = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic [4:0]  a0, a1, ra;
            logic [63:0] d0, d1, e;
            logic        c;
            wr_en     = 2'($urandom_range(0, 3));
            a0        = 5'($urandom_range(0, 7));
            a1        = 5'($urandom_range(0, 7));
            d0        = {$urandom, $urandom};
            d1        = {$urandom, $urandom};
            wr_addr   = {a1, a0};
            wr_data   = {d1, d0};
            rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            resv_en   = ($urandom_range(0, 3) == 0);
            resv_addr = 5'($urandom_range(0, 7));
            #1;
            for (int k = 0; k < 2; k++) begin
                ra = rd_addr[k*5 +: 5];
                e  = m_reg[ra];
                if (wr_en[1] && a1 == ra)      e = d1;
                else if (wr_en[0] && a0 == ra) e = d0;
                if (ra == 5'd0) e = '0;
                chk("rnd_rd_data", rd(k), e);
                chk("rnd_nb_rd_data", nbrd(k), (ra == 5'd0) ? 64'h0 : m_reg[ra]);
                chk("rnd_rd_busy", 64'(rd_busy[k]), 64'(m_busy[ra]));
                chk("rnd_nb_rd_busy", 64'(nb_rd_busy[k]), 64'(m_busy[ra]));
            end
            chk("rnd_busy_vec", 64'(busy_vec), 64'(m_busy));
            chk("rnd_nb_busy_vec", 64'(nb_busy_vec), 64'(m_busy));
            chk("rnd_coll", 64'(wr_collision), 64'(m_coll));
            chk("rnd_nb_coll", 64'(nb_wr_collision), 64'(m_coll));
            c = !m_busy[resv_addr] || (resv_addr == 5'd0);
            chk("rnd_resv_ok", 64'(resv_ok), 64'(c));

            m_coll = wr_en[0] && wr_en[1] && (a0 == a1) && (a0 != 5'd0);
            if (wr_en[0] && a0 != 5'd0) m_reg[a0] = d0;
            if (wr_en[1] && a1 != 5'd0) m_reg[a1] = d1;
            if (wr_en[0]) m_busy[a0] = 1'b0;
            if (wr_en[1]) m_busy[a1] = 1'b0;
            if (resv_en)  m_busy[resv_addr] = 1'b1;
            m_busy[0] = 1'b0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
